// File: rtl/led_meter.sv
// -----------------------------------------------------------------------------
// led_meter
//   Thermometer-style level meter with peak hold/decay and a sticky overload
//   flag. Each valid magnitude sample is converted to a level (number of
//   thresholds strictly exceeded). A peak tracker holds the highest recent
//   level for HOLD_CYC clocks, then lets it fall one step every DECAY_CYC
//   clocks until it meets the current level again.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   mag       : unsigned magnitude sample (WIDTH bits)
//   mag_vld   : mag is sampled on this clock
//   dot_mode  : 0 = bar display, 1 = dot display
//   clr_peak  : synchronous peak and overload clear
//   therm     : registered LED drive (NUM_LEDS bits)
//   peak_lvl  : registered current peak level
//   over      : registered sticky overload flag
// -----------------------------------------------------------------------------
module led_meter #(
  parameter int                          WIDTH     = 15,
  parameter int                          NUM_LEDS  = 9,
  parameter logic [NUM_LEDS*WIDTH-1:0]   THRESH    = {15'h66FF, 15'h507F, 15'h3E7F,
                                                      15'h2DFF, 15'h1FFF, 15'h147F,
                                                      15'h0B7F, 15'h057F, 15'h017F},
  parameter int                          HOLD_CYC  = 2500000,
  parameter int                          DECAY_CYC = 250000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [WIDTH-1:0]                    mag,
  input  logic                                mag_vld,
  input  logic                                dot_mode,
  input  logic                                clr_peak,
  output logic [NUM_LEDS-1:0]                 therm,
  output logic [$clog2(NUM_LEDS+1)-1:0]       peak_lvl,
  output logic                                over
);

  localparam int PW   = $clog2(NUM_LEDS + 1);
  localparam int TMAX = (HOLD_CYC > DECAY_CYC) ? HOLD_CYC : DECAY_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] DECAY_LD = TW'(DECAY_CYC - 1);
  localparam logic [PW-1:0] FULL_LVL = PW'(NUM_LEDS);

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } state_t;

  // Registered state
  state_t                state_r;
  logic [PW-1:0]         level_q_r;
  logic [PW-1:0]         peak_r;
  logic [TW-1:0]         timer_r;
  logic [NUM_LEDS-1:0]   therm_r;
  logic                  over_r;

  // Next-state values
  state_t                state_s;
  logic [PW-1:0]         level_s;
  logic [PW-1:0]         level_q_s;
  logic [PW-1:0]         peak_s;
  logic [TW-1:0]         timer_s;
  logic [NUM_LEDS-1:0]   therm_s;
  logic                  over_s;

  // Level of the incoming sample: count of thresholds strictly exceeded.
  always_comb begin
    level_s = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (mag > THRESH[i*WIDTH +: WIDTH]) begin
        level_s = level_s + PW'(1);
      end else begin
        level_s = level_s;
      end
    end
  end

  // Peak tracker next state. The comparisons use the level that will be held
  // after this clock, so a sample arriving together with a timer expiry is
  // already taken into account and peak can never fall below it.
  always_comb begin
    state_s   = state_r;
    peak_s    = peak_r;
    timer_s   = timer_r;
    level_q_s = mag_vld ? level_s : level_q_r;

    if (clr_peak) begin
      peak_s  = level_q_s;
      state_s = TRACK;
      timer_s = '0;
    end else if (mag_vld && (level_s >= peak_r)) begin
      peak_s  = level_s;
      state_s = HOLD;
      timer_s = HOLD_LD;
    end else begin
      case (state_r)
        TRACK: begin
          peak_s = level_q_s;
        end
        HOLD: begin
          if (timer_r == '0) begin
            if (peak_r > level_q_s) begin
              state_s = DECAY;
              timer_s = DECAY_LD;
            end else begin
              state_s = TRACK;
              peak_s  = level_q_s;
            end
          end else begin
            timer_s = timer_r - TW'(1);
          end
        end
        DECAY: begin
          if (timer_r == '0) begin
            peak_s = peak_r - PW'(1);
            if ((peak_r - PW'(1)) == level_q_s) begin
              state_s = TRACK;
              timer_s = '0;
            end else begin
              state_s = DECAY;
              timer_s = DECAY_LD;
            end
          end else begin
            timer_s = timer_r - TW'(1);
          end
        end
        default: begin
          state_s = TRACK;
          peak_s  = level_q_s;
          timer_s = '0;
        end
      endcase
    end
  end

  // Overload flag: a full-scale sample sets it and beats a coincident clear.
  always_comb begin
    if (mag_vld && (level_s == FULL_LVL)) begin
      over_s = 1'b1;
    end else if (clr_peak) begin
      over_s = 1'b0;
    end else begin
      over_s = over_r;
    end
  end

  // LED pattern built from the next-state level and peak, so the outputs land
  // on the same clock edge that captures the sample. Index i lights for
  // level/peak value i+1; a value of 0 matches no LED.
  always_comb begin
    therm_s = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (dot_mode) begin
        therm_s[i] = (PW'(i + 1) == level_q_s);
      end else begin
        therm_s[i] = (PW'(i) < level_q_s);
      end
      therm_s[i] = therm_s[i] | (PW'(i + 1) == peak_s);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= TRACK;
      level_q_r <= '0;
      peak_r    <= '0;
      timer_r   <= '0;
      therm_r   <= '0;
      over_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      level_q_r <= level_q_s;
      peak_r    <= peak_s;
      timer_r   <= timer_s;
      therm_r   <= therm_s;
      over_r    <= over_s;
    end
  end

  assign therm    = therm_r;
  assign peak_lvl = peak_r;
  assign over     = over_r;

endmodule

// File: tb/tb_led_meter.sv
// -----------------------------------------------------------------------------
// tb_led_meter
//   Scoreboard bench for led_meter (HOLD_CYC=4, DECAY_CYC=2). The stimulus
//   process drives one clock at a time, advances a timestamp-based reference
//   model and queues the expected outputs; a monitor on the falling edge pops
//   and compares. Directed scenarios add constant checks on top.
// -----------------------------------------------------------------------------
module tb_led_meter;

  localparam int HOLD  = 4;
  localparam int DECAY = 2;
  localparam int NL    = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] mag = 15'h0;
  logic        mag_vld = 1'b0;
  logic        dot_mode = 1'b0;
  logic        clr_peak = 1'b0;
  logic [8:0]  therm;
  logic [3:0]  peak_lvl;
  logic        over;

  led_meter #(.HOLD_CYC(HOLD), .DECAY_CYC(DECAY)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mag      (mag),
    .mag_vld  (mag_vld),
    .dot_mode (dot_mode),
    .clr_peak (clr_peak),
    .therm    (therm),
    .peak_lvl (peak_lvl),
    .over     (over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [8:0] t;
    logic [3:0] p;
    logic       o;
  } exp_t;
  exp_t sb_q[$];

  int th[NL] = '{32'h017F, 32'h057F, 32'h0B7F, 32'h147F, 32'h1FFF,
                 32'h2DFF, 32'h3E7F, 32'h507F, 32'h66FF};

  // Reference model: peak with absolute deadlines instead of a down-counter.
  int m_lq, m_peak, m_mode, m_cyc, m_deadline;
  bit m_over;
  localparam int M_TRACK = 0, M_HOLD = 1, M_DECAY = 2;

  task automatic m_reset();
    m_lq = 0; m_peak = 0; m_mode = M_TRACK; m_over = 1'b0; m_deadline = 0;
  endtask

  function automatic int lvl_of(input logic [14:0] m);
    int n;
    n = 0;
    for (int i = 0; i < NL; i++) if (int'(m) > th[i]) n++;
    return n;
  endfunction

  function automatic logic [8:0] exp_therm(input int lq, input int pk, input bit dot);
    logic [8:0] t;
    t = 9'h000;
    if (!dot) begin
      for (int i = 0; i < lq; i++) t[i] = 1'b1;
    end else if (lq > 0) begin
      t[lq-1] = 1'b1;
    end
    if (pk > 0) t[pk-1] = 1'b1;
    return t;
  endfunction

  task automatic m_step(input logic [14:0] m, input bit v, input bit d, input bit c);
    int lv, lqn;
    exp_t e;
    m_cyc++;
    lv  = lvl_of(m);
    lqn = v ? lv : m_lq;
    if (c) begin
      m_peak = lqn; m_mode = M_TRACK;
    end else if (v && lv >= m_peak) begin
      m_peak = lv; m_mode = M_HOLD; m_deadline = m_cyc + HOLD;
    end else if (m_mode == M_HOLD) begin
      if (m_cyc == m_deadline) begin
        if (m_peak > lqn) begin
          m_mode = M_DECAY; m_deadline = m_cyc + DECAY;
        end else begin
          m_mode = M_TRACK; m_peak = lqn;
        end
      end
    end else if (m_mode == M_DECAY) begin
      if (m_cyc == m_deadline) begin
        m_peak--;
        m_deadline = m_cyc + DECAY;
        if (m_peak == lqn) m_mode = M_TRACK;
      end
    end else begin
      m_peak = lqn;
    end
    if (v && lv == NL) m_over = 1'b1;
    else if (c) m_over = 1'b0;
    m_lq = lqn;
    e.t = exp_therm(m_lq, m_peak, d);
    e.p = 4'(m_peak);
    e.o = m_over;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic drive(input logic [14:0] m, input bit v, input bit d, input bit c);
    mag = m; mag_vld = v; dot_mode = d; clr_peak = c;
    @(posedge clk);
    m_step(m, v, d, c);
    #1;
  endtask

  task automatic idle(input int n, input bit d);
    for (int i = 0; i < n; i++) drive(15'h0, 1'b0, d, 1'b0);
  endtask

  // Monitor: compares every queued expectation against the DUT outputs.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      if (therm !== e.t || peak_lvl !== e.p || over !== e.o) begin
        bad++;
        $display("FAIL sb t=%0t therm act=%h exp=%h peak act=%0d exp=%0d over act=%b exp=%b",
                 $time, therm, e.t, peak_lvl, e.p, over, e.o);
      end
    end
  end

  initial begin
    logic [14:0] rm;
    int sel;
    bit rd;
    m_cyc = 0;
    m_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_therm", 32'(therm), 32'h0);
    chk("rst_peak",  32'(peak_lvl), 32'h0);
    chk("rst_over",  32'(over), 32'h0);
    rst_n = 1'b1;

    // Strict threshold compare at LED0
    drive(15'h017F, 1'b1, 1'b0, 1'b0);
    chk("thr_eq", 32'(therm), 32'h000);
    drive(15'h0180, 1'b1, 1'b0, 1'b0);
    chk("thr_gt", 32'(therm), 32'h001);

    // Full scale and overload clear
    drive(15'h7FFF, 1'b1, 1'b0, 1'b0);
    chk("full_therm", 32'(therm), 32'h1FF);
    chk("full_over",  32'(over), 32'h1);
    chk("full_peak",  32'(peak_lvl), 32'd9);
    drive(15'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_over", 32'(over), 32'h0);
    chk("clr_peak", 32'(peak_lvl), 32'd9);

    // Hold then decay from 6, restarted by a level-8 sample at peak 4
    drive(15'h0, 1'b1, 1'b0, 1'b1);
    drive(15'h2E00, 1'b1, 1'b0, 1'b0);
    chk("l6_peak", 32'(peak_lvl), 32'd6);
    drive(15'h0, 1'b1, 1'b0, 1'b0);
    chk("hold_therm", 32'(therm), 32'h020);
    idle(3, 1'b0);
    chk("hold_end", 32'(therm), 32'h020);
    idle(4, 1'b0);
    chk("decay4", 32'(peak_lvl), 32'd4);
    drive(15'h5080, 1'b1, 1'b0, 1'b0);
    chk("restart_peak",  32'(peak_lvl), 32'd8);
    chk("restart_therm", 32'(therm), 32'h0FF);
    drive(15'h0, 1'b1, 1'b0, 1'b0);
    idle(30, 1'b0);
    chk("decay0_peak",  32'(peak_lvl), 32'd0);
    chk("decay0_therm", 32'(therm), 32'h000);

    // Dot mode
    drive(15'h4000, 1'b1, 1'b1, 1'b0);
    drive(15'h0C00, 1'b1, 1'b1, 1'b0);
    chk("dot_3_7", 32'(therm), 32'h044);
    drive(15'h0, 1'b1, 1'b1, 1'b0);
    idle(40, 1'b1);
    chk("dot_0_0", 32'(therm), 32'h000);

    // Asynchronous reset mid-decay
    drive(15'h4000, 1'b1, 1'b0, 1'b0);
    drive(15'h0, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_therm", 32'(therm), 32'h0);
    chk("arst_peak",  32'(peak_lvl), 32'h0);
    chk("arst_over",  32'(over), 32'h0);
    #1 rst_n = 1'b1;
    m_reset();
    idle(3, 1'b0);
    chk("post_rst_peak", 32'(peak_lvl), 32'h0);

    // Randomized traffic against the model
    rd = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    rm = 15'h0;
        2:       rm = 15'h7FFF;
        3, 4, 5: rm = 15'(th[$urandom_range(0, NL-1)] + $urandom_range(0, 1));
        default: rm = 15'($urandom);
      endcase
      if ($urandom_range(0, 49) == 0) rd = ~rd;
      drive(rm, ($urandom_range(0, 2) == 0), rd, ($urandom_range(0, 39) == 0));
    end
    idle(2, rd);

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_meter.md
LED_METER -- requirements
Module: led_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 15: magnitude width in bits.
REQ-002 SHALL have parameter NUM_LEDS, default 9: number of thermometer segments.
REQ-003 SHALL have parameter THRESH, width NUM_LEDS*WIDTH, default {15'h66FF,15'h507F,15'h3E7F,15'h2DFF,15'h1FFF,15'h147F,15'h0B7F,15'h057F,15'h017F}: per-LED thresholds, LED0 in the LSBs, strictly ascending (not checked).
REQ-004 SHALL have parameter HOLD_CYC, default 2500000: peak-hold duration in clocks, minimum 1.
REQ-005 SHALL have parameter DECAY_CYC, default 250000: clocks per one-step peak decay, minimum 1.
REQ-006 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port mag, input, WIDTH bits: unsigned magnitude sample.
REQ-009 SHALL have port mag_vld, input, 1 bit: mag is sampled on this cycle.
REQ-010 SHALL have port dot_mode, input, 1 bit: 0 = bar display, 1 = dot display.
REQ-011 SHALL have port clr_peak, input, 1 bit: synchronous peak and overload clear.
REQ-012 SHALL have port therm, output, NUM_LEDS bits: LED drive, registered.
REQ-013 SHALL have port peak_lvl, output, $clog2(NUM_LEDS+1) bits: current peak level, registered.
REQ-014 SHALL have port over, output, 1 bit: sticky overload flag, registered.

Function
REQ-015 SHALL compute level as the count of i where mag > THRESH[i]; strict compare, so mag equal to a threshold does not light that LED.
REQ-016 SHALL load level_q with level on a clock where mag_vld=1, and hold level_q otherwise.
REQ-017 SHALL update therm, peak_lvl and over on the clock after mag_vld, giving 1-cycle latency.
REQ-018 SHALL implement a peak FSM with states TRACK, HOLD and DECAY, plus a timer sized for max(HOLD_CYC, DECAY_CYC).
REQ-019 SHALL, on a sample with level >= peak in any state, set peak to level, go to HOLD and load the timer with HOLD_CYC-1.
REQ-020 SHALL, in HOLD, decrement the timer each clock; at timer 0, if peak > level_q it SHALL go to DECAY with timer = DECAY_CYC-1, else go to TRACK.
REQ-021 SHALL, in DECAY, decrement peak by 1 each time the timer reaches 0 and reload the timer; when peak equals level_q it SHALL go to TRACK.
REQ-022 SHALL never decrement peak below level_q or below 0.
REQ-023 SHALL, in TRACK, hold peak equal to level_q.
REQ-024 SHALL, in bar mode, drive therm[i]=1 for i < level_q, and also drive therm[peak-1]=1 when peak > 0.
REQ-025 SHALL, in dot mode, drive only therm[level_q-1] and therm[peak-1], each only when its index is > 0.
REQ-026 SHALL apply a dot_mode change on the next therm update, with no effect on FSM state.
REQ-027 SHALL set over when a sampled level equals NUM_LEDS, and hold it until clr_peak.
REQ-028 SHALL, on clr_peak, set peak to the current level_q, enter TRACK and clear over on the next clock.
REQ-029 SHALL, when clr_peak coincides with mag_vld, use the new level for both peak and level_q; if that level equals NUM_LEDS, set wins and over stays 1.
REQ-030 SHALL let a new sample arriving during DECAY with level > peak restart HOLD per REQ-019.
REQ-031 SHALL accept samples on every clock with no back-pressure.

Reset
REQ-032 SHALL, with rst_n low, asynchronously force level_q=0, peak=0, timer=0, state=TRACK, therm=0, peak_lvl=0 and over=0.
REQ-033 SHALL, after reset is released mid-HOLD or mid-DECAY, resume in TRACK with all outputs 0 until the next mag_vld.

Verification (defaults, except HOLD_CYC=4 and DECAY_CYC=2)
REQ-034 SHALL cover: mag=15'h017F with vld, then 15'h0180 -> therm 9'h000, then 9'h001 one clock after each sample.
REQ-035 SHALL cover: mag=15'h7FFF with vld -> therm 9'h1FF, over=1, peak_lvl=9; then clr_peak alone -> over=0, peak_lvl=9.
REQ-036 SHALL cover: mag=15'h2E00 (level 6), then mag=0 -> therm 9'h020 for 4 clocks, then peak_lvl steps 6,5,...,0 every 2 clocks, FSM in TRACK at 0.
REQ-037 SHALL cover: peak 6 in DECAY at 4, then mag=15'h5080 (level 8) -> peak_lvl=8, HOLD restarts, therm 9'h0FF.
REQ-038 SHALL cover: dot_mode=1 with level 3 and peak 7 -> therm 9'h044; with level=peak=0 -> therm 9'h000.
REQ-039 SHALL cover: rst_n pulsed low mid-DECAY without a clock edge -> all outputs 0 immediately, TRACK after release.
